// File: rtl/led_toggle_divider_n_if.sv
// Board-side signal bundle for the LED toggle divider: raw switches and
// mode select in, LED drive and per-channel enable status out.
interface led_toggle_divider_n_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] sw;
  logic              mode;
  logic [NUM_CH-1:0] led;
  logic [NUM_CH-1:0] active;

  // The switch/mode side drives sw and mode and observes the LEDs
  modport master (
    output sw,
    output mode,
    input  led,
    input  active
  );

  // The divider consumes switches and mode and drives LEDs and status
  modport slave (
    input  sw,
    input  mode,
    output led,
    output active
  );
endinterface

// File: rtl/led_toggle_divider_n.sv
// Multi-channel LED toggle divider. Each channel's switch is synchronised
// and debounced; channel k then toggles its LED every BASE_HALF<<k cycles
// while enabled. In exclusive mode only the highest-index debounced switch
// is honoured.
module led_toggle_divider_n #(
  parameter int NUM_CH       = 4,
  parameter int BASE_HALF    = 2,
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  led_toggle_divider_n_if.slave   bus
);

  // The debounce counter only ever holds 0..DEBOUNCE_CYC-1
  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [NUM_CH-1:0] sw_meta;
  logic [NUM_CH-1:0] sw_sync;
  logic [NUM_CH-1:0] sw_db;
  logic [NUM_CH-1:0] en_excl;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] active_r;
  logic [NUM_CH-1:0] led_r;

  // Two-flop synchroniser bringing the asynchronous switches into clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= bus.sw;
      sw_sync <= sw_meta;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'((BASE_HALF << k) - 1);

      logic [DB_W-1:0]  db_cnt;
      logic             db_q;
      logic [CNT_W-1:0] cnt;
      logic             led_q;

      // Accept a new switch level only after it has differed for DEBOUNCE_CYC cycles in a row
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          db_cnt <= '0;
          db_q   <= 1'b0;
        end else if (sw_sync[k] == db_q) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          db_q   <= sw_sync[k];
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end

      assign sw_db[k] = db_q;

      // Half-period counter; disabling clears phase so a re-enable always starts fresh
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt   <= '0;
          led_q <= 1'b0;
        end else if (!active_r[k]) begin
          cnt   <= '0;
          led_q <= 1'b0;
        end else if (cnt == HALF_M1) begin
          cnt   <= '0;
          led_q <= ~led_q;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign led_r[k] = led_q;
    end
  endgenerate

  // Resolve enables: pass-through, or keep only the highest set debounced switch
  always_comb begin
    en_excl = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sw_db[i]) begin
        en_excl    = '0;
        en_excl[i] = 1'b1;
      end
    end
    en = bus.mode ? en_excl : sw_db;
  end

  // Register the resolved enables; they gate the channel counters and form the status output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_r <= '0;
    end else begin
      active_r <= en;
    end
  end

  assign bus.led    = led_r;
  assign bus.active = active_r;

endmodule

// File: tb/tb_led_toggle_divider_n.sv
// Scoreboard bench for led_toggle_divider_n (NUM_CH=4, BASE_HALF=2,
// DEBOUNCE_CYC=4). Each stimulus step records, per channel, the edge at
// which active rises and falls, and pushes the resulting per-edge LED and
// status expectations; a monitor pops and compares them on falling edges.
module tb_led_toggle_divider_n;

  localparam int NUM_CH = 4;
  localparam int BIG    = 1 << 30;

  typedef struct {
    int         edge_n;
    logic [3:0] exp_led;
    logic [3:0] exp_active;
  } exp_t;

  logic clk;
  logic reset_n;
  int   edge_cnt;
  int   tests_run;
  int   tests_failed;
  int   a_edge [NUM_CH];
  int   d_edge [NUM_CH];
  exp_t sb [$];

  led_toggle_divider_n_if #(.NUM_CH(NUM_CH)) bus_if ();

  led_toggle_divider_n #(
    .NUM_CH(NUM_CH),
    .BASE_HALF(2),
    .CNT_W(16),
    .DEBOUNCE_CYC(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so expectations can be tied to absolute edge numbers
  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int half_of(input int k);
    return 2 << k;
  endfunction

  // Status is high from the edge active rises up to (not including) the edge it falls
  function automatic logic [3:0] model_active(input int e);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++)
      r[k] = (e >= a_edge[k]) && (e < d_edge[k]);
    return r;
  endfunction

  // LED toggles every half period after active rises, keeps going on the falling edge, clears one edge later
  function automatic logic [3:0] model_led(input int e);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++)
      if ((e >= a_edge[k]) && (e <= d_edge[k]))
        r[k] = (((e - a_edge[k]) / half_of(k)) % 2) == 1;
    return r;
  endfunction

  task automatic push_range(input int first, input int count);
    exp_t x;
    for (int i = 0; i < count; i++) begin
      x.edge_n     = first + i;
      x.exp_led    = model_led(first + i);
      x.exp_active = model_active(first + i);
      sb.push_back(x);
    end
  endtask

  // Drive switches and mode just after an edge; returns the sampling edge number
  task automatic applyStimulus(input logic [3:0] sw_v, input logic mode_v, output int s);
    bus_if.sw   = sw_v;
    bus_if.mode = mode_v;
    s = edge_cnt + 1;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pop every expectation due at this edge and compare against the DUT
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].edge_n <= edge_cnt) begin
      exp_t x;
      x = sb.pop_front();
      if (x.edge_n < edge_cnt)
        checkOutput("stale_entry", 32'(x.edge_n), 32'(edge_cnt));
      else begin
        checkOutput($sformatf("led@%0d", x.edge_n), 32'(bus_if.led), 32'(x.exp_led));
        checkOutput($sformatf("active@%0d", x.edge_n), 32'(bus_if.active), 32'(x.exp_active));
      end
    end
  end

  // Global time bound
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int s2;
    int t;
    tests_run    = 0;
    tests_failed = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      a_edge[k] = BIG;
      d_edge[k] = BIG;
    end

    // Reset held with all switches up: nothing may light
    reset_n     = 1'b0;
    bus_if.sw   = 4'b1111;
    bus_if.mode = 1'b0;
    push_range(1, 5);
    wait_edges(5);

    // Release: all four channels come up together at sampling edge + 6
    reset_n = 1'b1;
    s = edge_cnt + 1;
    for (int k = 0; k < NUM_CH; k++) a_edge[k] = s + 6;
    push_range(s, 86);
    wait_edges(86);

    // Drop sw[3] while led[3] is high; active[3] falls at s2+6, led[3] clears at s2+7
    applyStimulus(4'b0111, 1'b0, s2);
    d_edge[3] = s2 + 6;
    push_range(s2, 20);
    wait_edges(20);

    // Pick an edge where some LED is lit, then assert reset between edges
    for (int i = 0; i < 16; i++) begin
      if (model_led(edge_cnt) != 4'b0000) break;
      push_range(edge_cnt + 1, 1);
      wait_edges(1);
    end
    checkOutput("pre_reset_lit", 32'(bus_if.led != 4'b0000), 32'd1);
    #5;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_led", 32'(bus_if.led), 32'd0);
    checkOutput("async_reset_active", 32'(bus_if.active), 32'd0);
    for (int k = 0; k < NUM_CH; k++) begin
      a_edge[k] = BIG;
      d_edge[k] = BIG;
    end
    bus_if.sw = 4'b0000;
    push_range(edge_cnt + 1, 3);
    wait_edges(3);
    reset_n = 1'b1;

    // Three-cycle glitch on sw[1] must be ignored
    applyStimulus(4'b0010, 1'b0, s);
    push_range(s, 15);
    wait_edges(3);
    bus_if.sw = 4'b0000;
    wait_edges(12);

    // Six-cycle hold on sw[1] is accepted, then released again
    applyStimulus(4'b0010, 1'b0, s);
    a_edge[1] = s + 6;
    d_edge[1] = s + 12;
    push_range(s, 20);
    wait_edges(6);
    bus_if.sw = 4'b0000;
    wait_edges(14);

    // Exclusive mode with 0111: only channel 2 runs
    applyStimulus(4'b0111, 1'b1, s);
    a_edge[2] = s + 6;
    push_range(s, 40);
    wait_edges(40);

    // Back to independent mode: channels 0 and 1 join on the next edge from phase 0
    bus_if.mode = 1'b0;
    t = edge_cnt + 1;
    a_edge[0] = t;
    a_edge[1] = t;
    d_edge[0] = BIG;
    d_edge[1] = BIG;
    push_range(t, 40);
    wait_edges(42);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/led_toggle_divider_n.md
Name: led_toggle_divider_n

Overview:
Parametrised successor to the switch-selected LED toggle counter. NUM_CH channels each drive one LED. Each LED toggles at its own divided rate, and channel k's half-period is BASE_HALF<<k clock cycles. Raw switch inputs are synchronised and debounced on-chip, and a mode input chooses between independent channel enables and exclusive highest-priority enable. The block sits between the board switches/LEDs and the PL clock domain.

Parameters:
NUM_CH, 4, number of switch/LED channels (1..8)
BASE_HALF, 2, half-period of channel 0 in clk cycles (>=1)
CNT_W, 16, width of each channel counter; must satisfy (BASE_HALF<<(NUM_CH-1)) <= 2**CNT_W
DEBOUNCE_CYC, 4, consecutive stable cycles needed to accept a switch change (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
sw  input  NUM_CH  raw switch levels, asynchronous to clk
mode  input  1  0 = independent enables, 1 = exclusive (highest set switch only); synchronous, used directly
led  output  NUM_CH  LED drive, one per channel
active  output  NUM_CH  effective per-channel enable after debounce and mode resolution (status)

Behaviour:
- Reset (reset_n=0, asynchronous): led=0, active=0, all counters=0, sync flops=0, debounced switch state sw_db=0, debounce counters=0.
- Synchroniser: two-stage, sw_meta<=sw then sw_sync<=sw_meta. The sampling edge is edge 1; sw_sync is valid after edge 2.
- Debounce, per channel:
  - If sw_sync[k]==sw_db[k]: db_cnt[k]<=0.
  - Otherwise db_cnt[k] increments.
  - On the edge where db_cnt[k]==DEBOUNCE_CYC-1 and the value still differs: sw_db[k]<=sw_sync[k], db_cnt[k]<=0.
  - Result: sw_db updates at edge 2+DEBOUNCE_CYC.
  - A pulse shorter than DEBOUNCE_CYC synced cycles is ignored, and any return to the old value restarts the count.
- Enable resolution (combinational from sw_db and mode):
  - mode=0: en=sw_db.
  - mode=1: en has at most one bit set, the highest-index set bit of sw_db.
  - active is registered: active<=en.
- Channel counter k:
  - If active[k]=0: cnt[k]<=0, led[k]<=0.
  - Else if cnt[k]==HALF_k-1, where HALF_k=BASE_HALF<<k: cnt[k]<=0 and led[k]<=~led[k].
  - Else cnt[k]<=cnt[k]+1.
  - LED period is 2*HALF_k cycles with 50% duty.
- Latency: led[k] first rises at edge 3+DEBOUNCE_CYC+HALF_k after the sampling edge. Breakdown: 2 synchroniser edges, DEBOUNCE_CYC, 1 for the active register, HALF_k.
- Disable: led[k] and cnt[k] clear on the edge after active[k] falls. There is no partial-period hold, and re-enable always restarts phase from 0.
- Mode change mid-operation: takes effect via active on the next edge. Channels losing enable clear; a newly enabled channel starts from cnt=0.
- Simultaneous switch changes: debounced independently per channel, with no ordering between channels.
- Wrap-around: counters never exceed HALF_k-1; the CNT_W constraint guarantees no overflow.
- Reset mid-operation: everything clears immediately, without waiting for clk. After release, switches already high are re-debounced from scratch, with the same latency as a fresh press.

Test Plan:
(Parameters for all scenarios: NUM_CH=4, BASE_HALF=2, DEBOUNCE_CYC=4, 10 ns clk. HALF_k = 2, 4, 8, 16.)
- Reset: reset_n=0 with sw=4'b1111 -> led=0 and active=0 throughout; after release, active=4'b1111 at edge 7 after the first sampling edge.
- Single channel: sw=4'b0001 from edge 1, mode=0 -> active[0] rises at edge 7; led[0] rises at edge 9 and then toggles every 2 cycles; led[3:1]=0.
- Rates: sw=4'b1111, mode=0 -> led[0..3] periods are exactly 4, 8, 16, 32 cycles, and all first rises are aligned to the same start edge.
- Glitch rejection: sw[1] high for 3 cycles, then low -> active[1] and led[1] never assert. sw[1] held 6 cycles -> active[1] asserts.
- Exclusive mode: sw=4'b0111, mode=1 -> active=4'b0100 and only led[2] toggles (period 16). Switching mode to 0 adds active[0] and active[1] on the next edge, each starting from phase 0.
- Disable and reset mid-count: clearing sw[3] while led[3]=1 -> led[3]=0 exactly one edge after active[3] falls. Asserting reset_n=0 between edges -> led=0 immediately, with no clk edge needed.
